// File: rtl/fetch_branch_unit.sv
// LEGv8 instruction-fetch stage with EX-stage branch resolution.
// Holds the PC, fills the IF/ID register and redirects/flushes on a taken branch.
module fetch_branch_unit #(
    parameter int unsigned          ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              ex_valid,
    input  logic              Uncondbranch,
    input  logic              Branch,
    input  logic              branch0,
    input  logic              BReg,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [31:0]       ex_imm,
    input  logic [ADDR_W-1:0] ex_reg,
    input  logic [3:0]        ex_cond,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic              flag_c,
    input  logic              flag_v,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              redirect,
    output logic [ADDR_W-1:0] link_pc,
    output logic [15:0]       taken_count
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [15:0]       taken_count_q, taken_count_d;

    logic              cond_met;
    logic              taken;
    logic [ADDR_W-1:0] branch_offset;
    logic [ADDR_W-1:0] target;

    // B.cond evaluation against the registered NZCV flags.
    always_comb begin
        // NOTE: a default on every path keeps this purely combinational (no latch).
        cond_met = 1'b0;
        unique case (ex_cond)
            4'b0000: cond_met = flag_z;
            4'b0001: cond_met = !flag_z;
            4'b0010: cond_met = flag_c;
            4'b0011: cond_met = !flag_c;
            4'b0100: cond_met = flag_n;
            4'b0101: cond_met = !flag_n;
            4'b0110: cond_met = flag_v;
            4'b0111: cond_met = !flag_v;
            4'b1000: cond_met = flag_c && !flag_z;
            4'b1001: cond_met = !(flag_c && !flag_z);
            4'b1010: cond_met = (flag_n == flag_v);
            4'b1011: cond_met = (flag_n != flag_v);
            4'b1100: cond_met = !flag_z && (flag_n == flag_v);
            4'b1101: cond_met = !(!flag_z && (flag_n == flag_v));
            default: cond_met = 1'b1;
        endcase
    end

    assign taken = ex_valid && (Uncondbranch || (branch0 && (ex_reg == '0)) || (Branch && cond_met));

    // Word offset sign-extended and scaled to bytes in one concatenation.
    assign branch_offset = {{(ADDR_W-34){ex_imm[31]}}, ex_imm, 2'b00};
    assign target        = BReg ? {ex_reg[ADDR_W-1:2], 2'b00} : (ex_pc + branch_offset);

    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        taken_count_d = taken_count_q;
        if (taken) begin
            // Redirect wins over stall and squashes the wrong-path fetch.
            pc_d          = target;
            if_id_instr_d = '0;
            if_id_valid_d = 1'b0;
            taken_count_d = taken_count_q + 16'd1;
        end else if (!stall) begin
            pc_d          = pc_q + PC_STEP;
            if_id_instr_d = imem_data;
            if_id_pc_d    = pc_q;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            pc_q          <= RESET_PC;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
            taken_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;
    assign taken_count = taken_count_q;
    assign redirect    = taken;
    assign link_pc     = ex_pc + PC_STEP;

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Directed bench for fetch_branch_unit: sequential fetch, B/CBZ/B.cond/BR redirects, reset.
module tb_fetch_branch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        ex_valid;
    logic        Uncondbranch;
    logic        Branch;
    logic        branch0;
    logic        BReg;
    logic [63:0] ex_pc;
    logic [31:0] ex_imm;
    logic [63:0] ex_reg;
    logic [3:0]  ex_cond;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic        redirect;
    logic [63:0] link_pc;
    logic [15:0] taken_count;

    int checks = 0;
    int errors = 0;

    fetch_branch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .ex_valid(ex_valid), .Uncondbranch(Uncondbranch), .Branch(Branch),
        .branch0(branch0), .BReg(BReg), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_reg(ex_reg), .ex_cond(ex_cond),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .redirect(redirect), .link_pc(link_pc), .taken_count(taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_branch();
        ex_valid = 0; Uncondbranch = 0; Branch = 0; branch0 = 0; BReg = 0;
    endtask

    initial begin
        reset = 0; stall = 0; imem_data = 32'hAAAA0001;
        clear_branch();
        ex_pc = '0; ex_imm = '0; ex_reg = '0; ex_cond = '0;
        flag_n = 0; flag_z = 0; flag_c = 0; flag_v = 0;

        tick();
        tick();
        check("rst_addr",  imem_addr,   64'h0);
        check("rst_valid", if_id_valid, 1'b0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_ifpc",  if_id_pc,    64'h0);
        check("rst_count", taken_count, 16'h0);

        // Sequential fetch.
        reset = 1;
        tick();
        check("seq1_addr",  imem_addr,   64'h4);
        check("seq1_ifpc",  if_id_pc,    64'h0);
        check("seq1_valid", if_id_valid, 1'b1);
        check("seq1_instr", if_id_instr, 32'hAAAA0001);
        tick();
        check("seq2_addr", imem_addr, 64'h8);
        check("seq2_ifpc", if_id_pc,  64'h4);
        tick();
        check("seq3_addr", imem_addr, 64'hC);
        check("seq3_ifpc", if_id_pc,  64'h8);

        // B forward: 0x40 + 3*4.
        ex_valid = 1; Uncondbranch = 1; ex_pc = 64'h40; ex_imm = 32'd3;
        #1;
        check("bf_redirect", redirect, 1'b1);
        check("bf_link",     link_pc,  64'h44);
        tick();
        check("bf_addr",  imem_addr,   64'h4C);
        check("bf_valid", if_id_valid, 1'b0);
        check("bf_instr", if_id_instr, 32'h0);
        check("bf_count", taken_count, 16'd1);
        clear_branch();
        tick();
        check("bf_next_addr",  imem_addr,   64'h50);
        check("bf_next_ifpc",  if_id_pc,    64'h4C);
        check("bf_next_valid", if_id_valid, 1'b1);

        // B backward under stall: 0x100 - 8.
        ex_valid = 1; Uncondbranch = 1; ex_pc = 64'h100; ex_imm = 32'hFFFFFFFE; stall = 1;
        #1;
        check("bb_redirect", redirect, 1'b1);
        check("bb_link",     link_pc,  64'h104);
        tick();
        check("bb_addr",  imem_addr,   64'hF8);
        check("bb_count", taken_count, 16'd2);
        check("bb_valid", if_id_valid, 1'b0);
        clear_branch();
        tick();
        check("stall_addr",  imem_addr,   64'hF8);
        check("stall_valid", if_id_valid, 1'b0);
        stall = 0;

        // CBZ taken then not taken.
        ex_valid = 1; branch0 = 1; ex_imm = 32'd2; ex_pc = 64'h20; ex_reg = 64'h0;
        #1;
        check("cbz0_redirect", redirect, 1'b1);
        tick();
        check("cbz0_addr",  imem_addr,   64'h28);
        check("cbz0_count", taken_count, 16'd3);
        ex_reg = 64'h5;
        #1;
        check("cbz5_redirect", redirect, 1'b0);
        tick();
        check("cbz5_addr",  imem_addr,   64'h2C);
        check("cbz5_count", taken_count, 16'd3);
        check("cbz5_valid", if_id_valid, 1'b1);

        // B.cond sweep.
        branch0 = 0; Branch = 1; ex_pc = 64'h200; ex_imm = 32'd1;
        flag_z = 0; flag_n = 1; flag_v = 1; ex_cond = 4'b1100;
        #1;
        check("gt_redirect", redirect, 1'b1);
        tick();
        check("gt_addr",  imem_addr,   64'h204);
        check("gt_count", taken_count, 16'd4);
        ex_cond = 4'b1011;
        #1;
        check("lt_redirect", redirect, 1'b0);
        ex_cond = 4'b1100; flag_z = 1;
        #1;
        check("gt_z_redirect", redirect, 1'b0);
        ex_cond = 4'b1111; ex_imm = 32'd4;
        #1;
        check("al_redirect", redirect, 1'b1);
        tick();
        check("al_addr",  imem_addr,   64'h210);
        check("al_count", taken_count, 16'd5);

        // Branch controls ignored without ex_valid; BReg alone is not a branch.
        clear_branch();
        Uncondbranch = 1;
        #1;
        check("novalid_redirect", redirect, 1'b0);
        clear_branch();
        ex_valid = 1; BReg = 1;
        #1;
        check("breg_only_redirect", redirect, 1'b0);

        // BR to a misaligned register target.
        Uncondbranch = 1; ex_reg = 64'h1003;
        #1;
        check("br_redirect", redirect, 1'b1);
        tick();
        check("br_addr",  imem_addr,   64'h1000);
        check("br_count", taken_count, 16'd6);
        clear_branch();
        tick();
        check("br_next_addr", imem_addr, 64'h1004);
        check("br_next_ifpc", if_id_pc,  64'h1000);

        // Reset during stall and a pending redirect discards both.
        stall = 1; ex_valid = 1; Uncondbranch = 1; reset = 0;
        tick();
        check("mrst_addr",  imem_addr,   64'h0);
        check("mrst_valid", if_id_valid, 1'b0);
        check("mrst_count", taken_count, 16'd0);
        check("mrst_ifpc",  if_id_pc,    64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
